// File: rtl/fifo_stream_adapter.sv
// ---------------------------------------------------------------------------
// fifo_stream_adapter
//
// Purpose:
//   Drains words from a synchronous FIFO that has a one-cycle read latency
//   and presents them on a valid/ready stream. A 2-entry skid buffer (head,
//   tail) absorbs the read latency. Reads are issued on a credit basis, so
//   the FIFO sustains one word per cycle under continuous downstream ready,
//   and backpressure never loses or duplicates a word.
//
// Parameters:
//   DATA_WIDTH   width of FIFO data and stream data
//   SKID_DEPTH   skid buffer entries; only 2 is supported
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_fifo_empty   FIFO empty flag
//   o_fifo_read    read strobe to the FIFO
//   i_fifo_data    FIFO read data, valid the cycle after an accepted read
//   o_valid        stream word valid
//   i_ready        downstream ready
//   o_data         stream data (head register)
//   o_word_count   number of words popped, wraps (FIFO_STREAM_ADAPTER_STATS_EN only)
//   o_busy         a word is buffered or a read is in flight
//
// Optional feature:
//   Define FIFO_STREAM_ADAPTER_STATS_EN to add the 32-bit o_word_count
//   output. Without it the port and counter are absent.
// ---------------------------------------------------------------------------
module fifo_stream_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_read,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    output logic [31:0]           o_word_count,
`endif
    output logic                  o_busy
);

    // The credit arithmetic and head/tail shifting below assume exactly two
    // entries; refuse to elaborate anything else.
    generate
        if (SKID_DEPTH != 2) begin : g_bad_depth
            $error("fifo_stream_adapter: SKID_DEPTH must be 2");
        end
    endgenerate

    logic [1:0]            occ_q,      occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q,     head_d;
    logic [DATA_WIDTH-1:0] tail_q,     tail_d;

    logic       pop;
    logic [2:0] level;
    logic       credit_ok;
    logic [1:0] occ_after_pop;

    assign o_valid = (occ_q != 2'd0);
    assign o_data  = head_q;
    assign o_busy  = (occ_q != 2'd0) | inflight_q;

    assign pop = o_valid & i_ready;

    // Words already committed to the buffer: stored plus one still arriving.
    // A new read is allowed only if, after this cycle's pop, there is a free
    // slot for it; this guarantees a capture never hits a full buffer.
    assign level     = {1'b0, occ_q} + {2'b00, inflight_q};
    assign credit_ok = (level < (3'd2 + {2'b00, pop}));

    // Gated by reset so no read is issued while the system FIFO is flushed.
    assign o_fifo_read = ~i_rst & ~i_fifo_empty & credit_ok;

    assign occ_after_pop = occ_q - {1'b0, pop};

    always_comb begin
        occ_d      = occ_after_pop;
        inflight_d = o_fifo_read;
        head_d     = head_q;
        tail_d     = tail_q;

        // Only shift when tail actually holds a word; otherwise head keeps
        // the last delivered value instead of picking up stale tail data.
        if (pop && (occ_q == 2'd2)) begin
            head_d = tail_q;
        end

        // Capture lands in head when the buffer is empty after the pop,
        // otherwise behind whatever head now holds.
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) begin
                head_d = i_fifo_data;
            end else begin
                tail_d = i_fifo_data;
            end
            occ_d = occ_after_pop + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0] word_count_q, word_count_d;

    // Natural 32-bit wrap from 0xFFFFFFFF to 0.
    always_comb begin
        word_count_d = word_count_q;
        if (pop) begin
            word_count_d = word_count_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_count_q <= 32'd0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign o_word_count = word_count_q;
`endif

endmodule
